// File: rtl/bolme_birimi.sv
// bolme_birimi: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module bolme_birimi #(
   parameter int VERI_BIT = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                basla_i,
   input  logic                iptal_i,
   input  logic [1:0]          kontrol_i,
   input  logic [VERI_BIT-1:0] bolunen_i,
   input  logic [VERI_BIT-1:0] bolen_i,
   output logic                mesgul_o,
   output logic                gecerli_o,
   output logic [VERI_BIT-1:0] sonuc_o
);
   localparam int W  = VERI_BIT;
   localparam int SW = $clog2(VERI_BIT + 1);
   typedef enum logic [1:0] {BOSTA, HESAPLA, BITTI} durum_t;
   durum_t         durum_q, durum_d;
   logic [W-1:0]   kalan_q, kalan_d, bolum_q, bolum_d, bolen_q, bolen_d, sonuc_q, sonuc_d;
   logic [SW-1:0]  sayac_q, sayac_d;
   logic           kalan_sec_q, kalan_sec_d, bolum_neg_q, bolum_neg_d, kalan_neg_q, kalan_neg_d;
   logic           mesgul_q, mesgul_d, gecerli_q, gecerli_d;
   logic           isaretli, a_neg, b_neg, sifir, tasma;
   logic [W-1:0]   abs_a, abs_b, q_son, r_son;
   logic [W:0]     kaydir, deneme;
   assign isaretli = ~kontrol_i[0];
   assign a_neg    = isaretli & bolunen_i[W-1];
   assign b_neg    = isaretli & bolen_i[W-1];
   assign abs_a    = a_neg ? -bolunen_i : bolunen_i;
   assign abs_b    = b_neg ? -bolen_i : bolen_i;
   assign sifir    = bolen_i == '0;
   assign tasma    = isaretli && bolunen_i == {1'b1, {(W-1){1'b0}}} && (&bolen_i);
   assign kaydir   = {kalan_q, bolum_q[W-1]};
   assign deneme   = kaydir - {1'b0, bolen_q};
   assign q_son    = bolum_neg_q ? -bolum_q : bolum_q;
   assign r_son    = kalan_neg_q ? -kalan_q : kalan_q;
   assign mesgul_o  = mesgul_q;
   assign gecerli_o = gecerli_q;
   assign sonuc_o   = sonuc_q;
   // Next state: accept/bypass in BOSTA, one quotient bit per HESAPLA cycle, sign fix-up in BITTI
   always_comb begin
      durum_d     = durum_q;
      kalan_d     = kalan_q;
      bolum_d     = bolum_q;
      bolen_d     = bolen_q;
      sonuc_d     = sonuc_q;
      sayac_d     = sayac_q;
      kalan_sec_d = kalan_sec_q;
      bolum_neg_d = bolum_neg_q;
      kalan_neg_d = kalan_neg_q;
      mesgul_d    = mesgul_q;
      gecerli_d   = 1'b0;
      if (durum_q == BOSTA) begin
         if (basla_i && !iptal_i) begin
            kalan_sec_d = kontrol_i[1];
            bolum_neg_d = a_neg ^ b_neg && !sifir;
            kalan_neg_d = a_neg;
            bolen_d     = abs_b;
            kalan_d     = sifir ? abs_a : '0;
            bolum_d     = sifir ? '1 : abs_a;
            sayac_d     = SW'(VERI_BIT);
            mesgul_d    = 1'b1;
            durum_d     = (sifir || tasma) ? BITTI : HESAPLA;
         end
      end else if (iptal_i) begin
         durum_d  = BOSTA;
         mesgul_d = 1'b0;
      end else if (durum_q == HESAPLA) begin
         kalan_d = deneme[W] ? kaydir[W-1:0] : deneme[W-1:0];
         bolum_d = {bolum_q[W-2:0], ~deneme[W]};
         sayac_d = sayac_q - 1'b1;
         if (sayac_q == SW'(1)) begin
            durum_d  = BITTI;
            mesgul_d = 1'b0;
         end
      end else begin
         sonuc_d   = kalan_sec_q ? r_son : q_son;
         gecerli_d = 1'b1;
         mesgul_d  = 1'b0;
         durum_d   = BOSTA;
      end
   end
   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q     <= BOSTA;
         kalan_q     <= '0;
         bolum_q     <= '0;
         bolen_q     <= '0;
         sonuc_q     <= '0;
         sayac_q     <= '0;
         kalan_sec_q <= 1'b0;
         bolum_neg_q <= 1'b0;
         kalan_neg_q <= 1'b0;
         mesgul_q    <= 1'b0;
         gecerli_q   <= 1'b0;
      end else begin
         durum_q     <= durum_d;
         kalan_q     <= kalan_d;
         bolum_q     <= bolum_d;
         bolen_q     <= bolen_d;
         sonuc_q     <= sonuc_d;
         sayac_q     <= sayac_d;
         kalan_sec_q <= kalan_sec_d;
         bolum_neg_q <= bolum_neg_d;
         kalan_neg_q <= kalan_neg_d;
         mesgul_q    <= mesgul_d;
         gecerli_q   <= gecerli_d;
      end
   end
endmodule

// File: tb/tb_bolme_birimi.sv
// tb_bolme_birimi: directed and random checks of bolme_birimi against an arithmetic model
module tb_bolme_birimi;
   logic        clk = 1'b0, rst, basla, iptal, mesgul, gecerli;
   logic [1:0]  kontrol;
   logic [31:0] a_i, b_i, sonuc;
   int          checks = 0, failures = 0;
   int          busy, gsay;
   always #5 clk = ~clk;
   bolme_birimi #(.VERI_BIT(32)) dut (
      .clk_i(clk), .rst_i(rst), .basla_i(basla), .iptal_i(iptal), .kontrol_i(kontrol),
      .bolunen_i(a_i), .bolen_i(b_i), .mesgul_o(mesgul), .gecerli_o(gecerli), .sonuc_o(sonuc)
   );
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      if (!op[0]) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return op[1] ? a % b : a / b;
   endfunction
   function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic baslat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      kontrol = op; a_i = a; b_i = b; basla = 1'b1;
      @(negedge clk);
      basla = 1'b0;
   endtask
   task automatic bekle(input string tag, input int k0, input int lat, input logic [31:0] exp, output int nb);
      int k;
      k = k0; nb = 0;
      while (!gecerli && k < 200) begin
         if (mesgul) nb++;
         @(negedge clk);
         k++;
      end
      chk({tag, " lat"}, 32'(k), 32'(lat));
      chk({tag, " val"}, sonuc, exp);
      chk({tag, " mesgul"}, {31'b0, mesgul}, 32'h0);
      @(negedge clk);
      chk({tag, " pulse"}, {31'b0, gecerli}, 32'h0);
   endtask
   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int nb;
      baslat(op, a, b);
      bekle(tag, 0, latency(op, a, b), model(op, a, b), nb);
   endtask
   task automatic say_gecerli(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (gecerli) c++;
      end
   endtask
   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      rst = 1'b1; basla = 1'b0; iptal = 1'b0; kontrol = 2'b00; a_i = '0; b_i = '0;
      repeat (2) @(negedge clk);
      chk("rst mesgul", {31'b0, mesgul}, 32'h0);
      chk("rst gecerli", {31'b0, gecerli}, 32'h0);
      chk("rst sonuc", sonuc, 32'h0);
      rst = 1'b0;
      baslat(2'b01, 32'd100, 32'd7);
      bekle("divu100_7", 0, 33, 32'd14, busy);
      chk("divu100_7 busy", 32'(busy), 32'd32);
      run("div-7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
      chk("div-7_2 const", sonuc, 32'hFFFF_FFFD);
      run("rem-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      chk("rem-7_2 const", sonuc, 32'hFFFF_FFFF);
      run("remu-7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
      run("divu0", 2'b01, 32'h1234_5678, 32'd0);
      run("rem0", 2'b10, 32'h1234_5678, 32'd0);
      run("div0neg", 2'b00, 32'hFFFF_FFF9, 32'd0);
      run("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run("divu big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      baslat(2'b01, 32'd1000, 32'd10);
      repeat (9) @(negedge clk);
      kontrol = 2'b00; a_i = 32'd77; b_i = 32'd5; basla = 1'b1;
      @(negedge clk);
      basla = 1'b0;
      bekle("busy ign", 10, 33, 32'd100, busy);
      baslat(2'b01, 32'd5000, 32'd7);
      repeat (14) @(negedge clk);
      iptal = 1'b1;
      @(negedge clk);
      iptal = 1'b0;
      chk("flush mesgul", {31'b0, mesgul}, 32'h0);
      say_gecerli(40, gsay);
      chk("flush no pulse", 32'(gsay), 32'h0);
      chk("flush sonuc", sonuc, 32'd100);
      @(negedge clk);
      kontrol = 2'b01; a_i = 32'd50; b_i = 32'd5; basla = 1'b1; iptal = 1'b1;
      @(negedge clk);
      basla = 1'b0; iptal = 1'b0;
      chk("iptal+basla mesgul", {31'b0, mesgul}, 32'h0);
      say_gecerli(40, gsay);
      chk("iptal+basla no pulse", 32'(gsay), 32'h0);
      baslat(2'b01, 32'd123456, 32'd789);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst mesgul", {31'b0, mesgul}, 32'h0);
      chk("midrst sonuc", sonuc, 32'h0);
      chk("midrst gecerli", {31'b0, gecerli}, 32'h0);
      run("divu9_3", 2'b01, 32'd9, 32'd3);
      chk("divu9_3 const", sonuc, 32'd3);
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run("rand", op, a, b);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
